// File: rtl/clock_pkg.sv
// Shared definitions for the clock set-mode controller and the timekeeping counter:
// state encoding, field limits and calendar helpers.
package clock_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHour  = 3'd1,
        StMin   = 3'd2,
        StSec   = 3'd3,
        StDay   = 3'd4,
        StMonth = 3'd5,
        StYear  = 3'd6
    } state_e;

    localparam int unsigned HourMax    = 23;
    localparam int unsigned MinMax     = 59;
    localparam int unsigned SecMax     = 59;
    localparam int unsigned DayMin     = 1;
    localparam int unsigned MonthMin   = 1;
    localparam int unsigned MonthMax   = 12;
    localparam int unsigned YearMinDef = 2000;
    localparam int unsigned YearMaxDef = 2999;

    function automatic logic is_leap(input logic [11:0] year);
        logic div4, div100, div400;
        div4   = (year[1:0] == 2'b00);
        div100 = ((year % 12'd100) == 12'd0);
        div400 = ((year % 12'd400) == 12'd0);
        return (div4 && !div100) || div400;
    endfunction

    function automatic logic [5:0] days_in_month(input logic [3:0] month,
                                                 input logic [11:0] year);
        logic [5:0] dim;
        case (month)
            4'd2:                      dim = is_leap(year) ? 6'd29 : 6'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 6'd30;
            default:                   dim = 6'd31;
        endcase
        return dim;
    endfunction

    // Field order walked by the set button; the last field hands back to idle.
    function automatic state_e next_set_state(input state_e s);
        state_e n;
        case (s)
            StHour:  n = StMin;
            StMin:   n = StSec;
            StSec:   n = StDay;
            StDay:   n = StMonth;
            StMonth: n = StYear;
            default: n = StIdle;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, running-value and edited-value bundle between the set controller and the
// board/counter side.
interface clock_set_ctrl_if;

    logic        btn_set;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_view;

    logic [4:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;
    logic [5:0]  cur_day;
    logic [3:0]  cur_month;
    logic [11:0] cur_year;

    logic        set_hour;
    logic        set_min;
    logic        set_sec;
    logic        set_day;
    logic        set_month;
    logic        set_year;
    logic        mode_date;

    logic [4:0]  new_hour;
    logic [5:0]  new_min;
    logic [5:0]  new_sec;
    logic [5:0]  new_day;
    logic [3:0]  new_month;
    logic [11:0] new_year;
    logic        load;

    modport master (
        output btn_set, btn_inc, btn_dec, btn_view,
        output cur_hour, cur_min, cur_sec, cur_day, cur_month, cur_year,
        input  set_hour, set_min, set_sec, set_day, set_month, set_year, mode_date,
        input  new_hour, new_min, new_sec, new_day, new_month, new_year, load
    );

    modport slave (
        input  btn_set, btn_inc, btn_dec, btn_view,
        input  cur_hour, cur_min, cur_sec, cur_day, cur_month, cur_year,
        output set_hour, set_min, set_sec, set_day, set_month, set_year, mode_date,
        output new_hour, new_min, new_sec, new_day, new_month, new_year, load
    );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous debounced button followed by a
// rising-edge detector producing a one-cycle pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1_q, sync2_q, edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~edge_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven set-mode controller: captures the running time/date, steps through and
// edits each field with calendar-correct wrap, and commits with a one-cycle load.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned YEAR_MIN    = YearMinDef,
    parameter int unsigned YEAR_MAX    = YearMaxDef,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input logic             clk,
    input logic             rst_n,
    clock_set_ctrl_if.slave bus
);

    localparam int unsigned   CntW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [11:0]   YMin    = 12'(YEAR_MIN);
    localparam logic [11:0]   YMax    = 12'(YEAR_MAX);

    logic set_p, inc_p, dec_p, view_p;

    btn_edge u_set  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_set),  .pulse(set_p));
    btn_edge u_inc  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_inc),  .pulse(inc_p));
    btn_edge u_dec  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_dec),  .pulse(dec_p));
    btn_edge u_view (.clk(clk), .rst_n(rst_n), .btn(bus.btn_view), .pulse(view_p));

    state_e      state_q, state_d;
    logic        view_q, view_d;
    logic        load_q, load_d;
    logic [5:0]  set_q, set_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  day_q, day_d;
    logic [3:0]  month_q, month_d;
    logic [11:0] year_q, year_d;

    logic        any_edge, step_up, step_dn;
    logic [4:0]  hour_s;
    logic [5:0]  min_s, sec_s, day_s;
    logic [3:0]  month_s;
    logic [11:0] year_s;
    logic [5:0]  dim_cur, dim_mo, dim_yr;

    assign any_edge = set_p | inc_p | dec_p | view_p;
    // Simultaneous inc and dec cancel out.
    assign step_up  = inc_p & ~dec_p;
    assign step_dn  = dec_p & ~inc_p;

    // Candidate stepped values; wrap by explicit compare at each field's own width.
    assign hour_s  = step_up ? ((hour_q >= 5'(HourMax)) ? 5'd0 : hour_q + 5'd1)
                             : ((hour_q == 5'd0) ? 5'(HourMax) : hour_q - 5'd1);
    assign min_s   = step_up ? ((min_q >= 6'(MinMax)) ? 6'd0 : min_q + 6'd1)
                             : ((min_q == 6'd0) ? 6'(MinMax) : min_q - 6'd1);
    assign sec_s   = step_up ? ((sec_q >= 6'(SecMax)) ? 6'd0 : sec_q + 6'd1)
                             : ((sec_q == 6'd0) ? 6'(SecMax) : sec_q - 6'd1);
    assign month_s = step_up ? ((month_q >= 4'(MonthMax)) ? 4'(MonthMin) : month_q + 4'd1)
                             : ((month_q <= 4'(MonthMin)) ? 4'(MonthMax) : month_q - 4'd1);
    assign year_s  = step_up ? ((year_q >= YMax) ? YMin : year_q + 12'd1)
                             : ((year_q <= YMin) ? YMax : year_q - 12'd1);

    assign dim_cur = days_in_month(month_q, year_q);
    assign dim_mo  = days_in_month(month_s, year_q);
    assign dim_yr  = days_in_month(month_q, year_s);

    assign day_s   = step_up ? ((day_q >= dim_cur) ? 6'(DayMin) : day_q + 6'd1)
                             : ((day_q <= 6'(DayMin)) ? dim_cur : day_q - 6'd1);

    always_comb begin
        state_d = state_q;
        view_d  = view_q;
        load_d  = 1'b0;
        cnt_d   = cnt_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (set_p) begin
                    hour_d  = bus.cur_hour;
                    min_d   = bus.cur_min;
                    sec_d   = bus.cur_sec;
                    day_d   = bus.cur_day;
                    month_d = bus.cur_month;
                    year_d  = bus.cur_year;
                    state_d = StHour;
                end else if (view_p) begin
                    view_d = ~view_q;
                end
            end
            default: begin
                if (set_p) begin
                    state_d = next_set_state(state_q);
                    load_d  = (state_q == StYear);
                end else if (step_up || step_dn) begin
                    unique case (state_q)
                        StHour:  hour_d = hour_s;
                        StMin:   min_d  = min_s;
                        StSec:   sec_d  = sec_s;
                        StDay:   day_d  = day_s;
                        StMonth: begin
                            month_d = month_s;
                            if (day_q > dim_mo) day_d = dim_mo;
                        end
                        StYear: begin
                            year_d = year_s;
                            if (day_q > dim_yr) day_d = dim_yr;
                        end
                        default: ;
                    endcase
                end

                // Abandon the edit without commit after a long stretch of no activity.
                if (any_edge) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    // Blink selects are decoded from the next state so they line up with state_q.
    always_comb begin
        set_d = '0;
        unique case (state_d)
            StHour:  set_d[5] = 1'b1;
            StMin:   set_d[4] = 1'b1;
            StSec:   set_d[3] = 1'b1;
            StDay:   set_d[2] = 1'b1;
            StMonth: set_d[1] = 1'b1;
            StYear:  set_d[0] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            view_q  <= 1'b0;
            load_q  <= 1'b0;
            set_q   <= '0;
            cnt_q   <= '0;
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            day_q   <= 6'(DayMin);
            month_q <= 4'(MonthMin);
            year_q  <= YMin;
        end else begin
            state_q <= state_d;
            view_q  <= view_d;
            load_q  <= load_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

    assign bus.set_hour  = set_q[5];
    assign bus.set_min   = set_q[4];
    assign bus.set_sec   = set_q[3];
    assign bus.set_day   = set_q[2];
    assign bus.set_month = set_q[1];
    assign bus.set_year  = set_q[0];

    assign bus.mode_date = (state_q == StIdle) ? view_q
                         : (state_q == StDay || state_q == StMonth || state_q == StYear);

    assign bus.new_hour  = hour_q;
    assign bus.new_min   = min_q;
    assign bus.new_sec   = sec_q;
    assign bus.new_day   = day_q;
    assign bus.new_month = month_q;
    assign bus.new_year  = year_q;
    assign bus.load      = load_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expected snapshots are queued as each button
// step is driven and compared once the DUT has had its three edges to react.
module tb_clock_set_ctrl;

    typedef struct {
        string       tag;
        logic [5:0]  set_v;
        logic        mode;
        logic        ld;
        logic [4:0]  h;
        logic [5:0]  mi;
        logic [5:0]  s;
        logic [5:0]  d;
        logic [3:0]  mo;
        logic [11:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   load_cnt = 0;
    exp_t e;
    exp_t sbq[$];

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .YEAR_MIN   (2000),
        .YEAR_MAX   (2999),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.load === 1'b1) load_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag);
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic check_pop();
        exp_t x;
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL sb_empty obs=0 exp=1");
        end
        if (sbq.size() != 0) begin
            x = sbq.pop_front();
            chk({x.tag, ".set"}, 12'({bus.set_hour, bus.set_min, bus.set_sec,
                                      bus.set_day, bus.set_month, bus.set_year}), 12'(x.set_v));
            chk({x.tag, ".mode"},  12'(bus.mode_date), 12'(x.mode));
            chk({x.tag, ".load"},  12'(bus.load),      12'(x.ld));
            chk({x.tag, ".hour"},  12'(bus.new_hour),  12'(x.h));
            chk({x.tag, ".min"},   12'(bus.new_min),   12'(x.mi));
            chk({x.tag, ".sec"},   12'(bus.new_sec),   12'(x.s));
            chk({x.tag, ".day"},   12'(bus.new_day),   12'(x.d));
            chk({x.tag, ".month"}, 12'(bus.new_month), 12'(x.mo));
            chk({x.tag, ".year"},  bus.new_year,       x.y);
        end
    endtask

    task automatic set_cur(input int h, input int mi, input int s, input int d,
                           input int mo, input int y);
        bus.cur_hour  = 5'(h);
        bus.cur_min   = 6'(mi);
        bus.cur_sec   = 6'(s);
        bus.cur_day   = 6'(d);
        bus.cur_month = 4'(mo);
        bus.cur_year  = 12'(y);
    endtask

    task automatic exp_reset();
        e.set_v = 6'b0; e.mode = 1'b0; e.ld = 1'b0;
        e.h = 5'd0; e.mi = 6'd0; e.s = 6'd0; e.d = 6'd1; e.mo = 4'd1; e.y = 12'd2000;
    endtask

    task automatic exp_cur(input logic [5:0] set_v);
        e.set_v = set_v; e.mode = 1'b0; e.ld = 1'b0;
        e.h = bus.cur_hour; e.mi = bus.cur_min; e.s = bus.cur_sec;
        e.d = bus.cur_day; e.mo = bus.cur_month; e.y = bus.cur_year;
    endtask

    // Inputs rise just after a clock edge; the third following edge is when they act.
    task automatic press(input logic s, input logic i, input logic d, input logic v);
        bus.btn_set = s; bus.btn_inc = i; bus.btn_dec = d; bus.btn_view = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_btns();
        bus.btn_set = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_view = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic s, input logic i, input logic d,
                        input logic v);
        push(tag);
        press(s, i, d, v);
        check_pop();
        release_btns();
    endtask

    task automatic commit(input string tag);
        e.set_v = 6'b0; e.mode = 1'b0; e.ld = 1'b1;
        push(tag);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_pop();
        @(posedge clk);
        #1;
        e.ld = 1'b0;
        push({tag, "_drop"});
        check_pop();
        release_btns();
    endtask

    initial begin
        bus.btn_set = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_view = 1'b0;
        set_cur(23, 59, 58, 31, 12, 2999);
        exp_reset();
        #12;
        push("reset");
        check_pop();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full edit pass with wraps, then commit.
        exp_cur(6'b100000);
        step("capture", 1, 0, 0, 0);
        e.h = 5'd0;         step("hour_inc_wrap", 0, 1, 0, 0);
        e.set_v = 6'b010000; step("to_min", 1, 0, 0, 0);
        e.mi = 6'd0;        step("min_inc_wrap", 0, 1, 0, 0);
        e.mi = 6'd59;       step("min_dec_wrap", 0, 0, 1, 0);
        e.set_v = 6'b001000; step("to_sec", 1, 0, 0, 0);
        step("sec_inc_dec", 0, 1, 1, 0);
        e.set_v = 6'b000100; e.mode = 1'b1; step("to_day", 1, 0, 0, 0);
        e.set_v = 6'b000010; step("to_month", 1, 0, 0, 0);
        e.mo = 4'd1;        step("month_inc_wrap", 0, 1, 0, 0);
        e.set_v = 6'b000001; step("to_year", 1, 0, 0, 0);
        e.y = 12'd2000;     step("year_inc_wrap", 0, 1, 0, 0);
        e.y = 12'd2999;     step("year_dec_wrap", 0, 0, 1, 0);
        commit("commit_a");
        chk("load_cnt_a", 12'(load_cnt), 12'd1);

        // Leap-year clamps on month and year change; set beats inc.
        set_cur(12, 30, 45, 31, 1, 2024);
        exp_cur(6'b100000);
        step("capture_b", 1, 0, 0, 0);
        e.set_v = 6'b010000; step("set_wins", 1, 1, 0, 0);
        e.set_v = 6'b001000; step("to_sec_b", 1, 0, 0, 0);
        e.set_v = 6'b000100; e.mode = 1'b1; step("to_day_b", 1, 0, 0, 0);
        e.set_v = 6'b000010; step("to_month_b", 1, 0, 0, 0);
        e.mo = 4'd2; e.d = 6'd29; step("month_leap_clamp", 0, 1, 0, 0);
        e.set_v = 6'b000001; step("to_year_b", 1, 0, 0, 0);
        e.y = 12'd2025; e.d = 6'd28; step("year_clamp", 0, 1, 0, 0);
        commit("commit_b");
        chk("load_cnt_b", 12'(load_cnt), 12'd2);

        // Day wrap, century non-leap clamp, then abandon by timeout.
        set_cur(8, 15, 0, 31, 1, 2100);
        exp_cur(6'b100000);
        step("capture_c", 1, 0, 0, 0);
        e.set_v = 6'b010000; step("to_min_c", 1, 0, 0, 0);
        e.set_v = 6'b001000; step("to_sec_c", 1, 0, 0, 0);
        e.set_v = 6'b000100; e.mode = 1'b1; step("to_day_c", 1, 0, 0, 0);
        e.d = 6'd1;         step("day_inc_wrap", 0, 1, 0, 0);
        e.d = 6'd31;        step("day_dec_wrap", 0, 0, 1, 0);
        e.set_v = 6'b000010; step("to_month_c", 1, 0, 0, 0);
        e.mo = 4'd2; e.d = 6'd28; step("month_2100_clamp", 0, 1, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        e.set_v = 6'b0; e.mode = 1'b0;
        push("timeout_c");
        check_pop();
        chk("load_cnt_c", 12'(load_cnt), 12'd2);

        // View toggle, view ignored while setting, exact timeout count from S_MIN.
        e.mode = 1'b1;      step("view_on", 0, 0, 0, 1);
        set_cur(1, 2, 3, 4, 5, 2001);
        exp_cur(6'b100000);
        step("capture_e", 1, 0, 0, 0);
        step("view_ignored", 0, 0, 0, 1);
        e.set_v = 6'b010000;
        push("to_min_e");
        press(1, 0, 0, 0);
        check_pop();
        release_btns();
        repeat (12) @(posedge clk);
        #1;
        push("before_timeout");
        check_pop();
        @(posedge clk);
        #1;
        e.set_v = 6'b0; e.mode = 1'b1;
        push("timeout_e");
        check_pop();
        chk("load_cnt_e", 12'(load_cnt), 12'd2);
        e.mode = 1'b0;      step("view_off", 0, 0, 0, 1);

        // Asynchronous reset in the middle of a set sequence.
        set_cur(10, 20, 30, 15, 6, 2500);
        exp_cur(6'b100000);
        step("capture_f", 1, 0, 0, 0);
        e.set_v = 6'b010000; step("to_min_f", 1, 0, 0, 0);
        e.set_v = 6'b001000; step("to_sec_f", 1, 0, 0, 0);
        e.set_v = 6'b000100; e.mode = 1'b1; step("to_day_f", 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_reset();
        push("async_reset");
        check_pop();
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        push("after_reset");
        check_pop();
        chk("load_cnt_f", 12'(load_cnt), 12'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
